// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single-port unified memory.
// The core (C) has priority; the DMA/loader (D) is forced through after MAX_WAIT lost cycles.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic       IDLE     = 1'b0;
  localparam logic       RD_WAIT  = 1'b1;
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic       state_r;
  logic [2:0] lat_cnt_r;
  logic       owner_r;
  logic [3:0] wait_cnt_r;

  logic rv_cycle_s;
  logic elig_s;
  logic force_d_s;
  logic c_win_s;
  logic d_win_s;
  logic rd_gnt_s;

  // Grant eligibility and winner selection
  always_comb begin
    rv_cycle_s = (state_r == RD_WAIT) && (lat_cnt_r == 3'd1);
    elig_s     = (state_r == IDLE) || rv_cycle_s;
    force_d_s  = (wait_cnt_r >= WAIT_LIM);
    c_win_s    = elig_s && c_req && (!d_req || !force_d_s);
    d_win_s    = elig_s && d_req && (!c_req || force_d_s);
    rd_gnt_s   = (c_win_s && !c_we) || (d_win_s && !d_we);
  end

  // Grant and memory-port drive; everything forced low while in reset
  always_comb begin
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (rst) begin
      c_gnt = 1'b0;
    end else if (c_win_s) begin
      c_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_win_s) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Read-return steering to the owner of the outstanding read
  always_comb begin
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    c_rdata  = {DW{1'b0}};
    d_rdata  = {DW{1'b0}};
    busy     = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      busy = (state_r == RD_WAIT);
      if (rv_cycle_s && !owner_r) begin
        c_rvalid = 1'b1;
        c_rdata  = mem_rdata;
      end else if (rv_cycle_s && owner_r) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end else begin
        c_rvalid = 1'b0;
      end
    end
  end

  // Read FSM: latency countdown with reload on a back-to-back read grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      lat_cnt_r <= 3'd0;
      owner_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_gnt_s) begin
            state_r   <= RD_WAIT;
            lat_cnt_r <= LAT_INIT;
            owner_r   <= d_win_s;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_r == 3'd1) begin
            if (rd_gnt_s) begin
              state_r   <= RD_WAIT;
              lat_cnt_r <= LAT_INIT;
              owner_r   <= d_win_s;
            end else begin
              state_r   <= IDLE;
              lat_cnt_r <= 3'd0;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          lat_cnt_r <= 3'd0;
          owner_r   <= 1'b0;
        end
      endcase
    end
  end

  // Anti-starvation counter: counts every cycle D waits, eligible or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
    end else if (d_win_s) begin
      wait_cnt_r <= 4'd0;
    end else if (d_req && (wait_cnt_r != 4'd15)) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with RD_LAT 1,2,3, each with a memory macro
// model and a transaction-level reference model, plus directed sequences.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_req [N];
  logic        c_we [N];
  logic [31:0] c_addr [N];
  logic [31:0] c_wdata [N];
  logic        c_gnt [N];
  logic        c_rvalid [N];
  logic [31:0] c_rdata [N];
  logic        d_req [N];
  logic        d_we [N];
  logic [31:0] d_addr [N];
  logic [31:0] d_wdata [N];
  logic        d_gnt [N];
  logic        d_rvalid [N];
  logic [31:0] d_rdata [N];
  logic        mem_en [N];
  logic        mem_we [N];
  logic [31:0] mem_addr [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        busy [N];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'hA5000000 ^ (32'(i) * 32'h00010203);
    if (i == 32'h40) w = 32'hDEADBEEF;
    return w;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gen_inst
    localparam int L = g + 1;
    logic [31:0] mem [256];
    logic [31:0] pipe [4];

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(L), .MAX_WAIT(MW)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_gnt(c_gnt[g]), .c_rvalid(c_rvalid[g]), .c_rdata(c_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    assign mem_rdata[g] = pipe[L-1];

    // Memory macro: fixed-latency read pipe, junk on the bus when no read is returning
    initial begin : mem_macro
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      for (int i = 0; i < 4; i++) pipe[i] = 32'h0;
      forever begin
        @(posedge clk);
        if (mem_en[g] && mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
        pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][9:2]] : $urandom;
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end

    // Reference model: eligibility as "next free cycle", one pending read with a due cycle
    initial begin : ref_model
      logic [31:0] rmem [256];
      int          cyc, nxt, due, wc;
      bit          pend, own, elig, rv, cw, dw;
      logic [31:0] rdat, e_addr, e_wdata;
      logic        e_we;
      string       p;
      for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
      cyc = 0; nxt = 0; due = 0; wc = 0; pend = 1'b0; own = 1'b0; rdat = 32'h0;
      p = $sformatf("i%0d", g);
      forever begin
        @(negedge clk);
        if (rst) begin
          chk({p, " rst c_gnt"}, c_gnt[g], 32'h0);
          chk({p, " rst d_gnt"}, d_gnt[g], 32'h0);
          chk({p, " rst c_rvalid"}, c_rvalid[g], 32'h0);
          chk({p, " rst d_rvalid"}, d_rvalid[g], 32'h0);
          chk({p, " rst c_rdata"}, c_rdata[g], 32'h0);
          chk({p, " rst d_rdata"}, d_rdata[g], 32'h0);
          chk({p, " rst mem_en"}, mem_en[g], 32'h0);
          chk({p, " rst mem_we"}, mem_we[g], 32'h0);
          chk({p, " rst mem_addr"}, mem_addr[g], 32'h0);
          chk({p, " rst mem_wdata"}, mem_wdata[g], 32'h0);
          chk({p, " rst busy"}, busy[g], 32'h0);
          pend = 1'b0; wc = 0; nxt = 0;
        end else begin
          elig = (cyc >= nxt);
          rv   = pend && (due == cyc);
          cw = 1'b0; dw = 1'b0;
          if (elig && c_req[g] && d_req[g]) begin
            if (wc >= MW) dw = 1'b1; else cw = 1'b1;
          end else if (elig && c_req[g]) cw = 1'b1;
          else if (elig && d_req[g]) dw = 1'b1;
          e_we    = cw ? c_we[g] : (dw ? d_we[g] : 1'b0);
          e_addr  = cw ? c_addr[g] : (dw ? d_addr[g] : 32'h0);
          e_wdata = cw ? c_wdata[g] : (dw ? d_wdata[g] : 32'h0);
          chk({p, " c_gnt"}, c_gnt[g], {31'h0, cw});
          chk({p, " d_gnt"}, d_gnt[g], {31'h0, dw});
          chk({p, " mem_en"}, mem_en[g], {31'h0, cw | dw});
          chk({p, " mem_we"}, mem_we[g], {31'h0, e_we});
          chk({p, " mem_addr"}, mem_addr[g], e_addr);
          chk({p, " mem_wdata"}, mem_wdata[g], e_wdata);
          chk({p, " c_rvalid"}, c_rvalid[g], {31'h0, rv && !own});
          chk({p, " d_rvalid"}, d_rvalid[g], {31'h0, rv && own});
          chk({p, " c_rdata"}, c_rdata[g], (rv && !own) ? rdat : 32'h0);
          chk({p, " d_rdata"}, d_rdata[g], (rv && own) ? rdat : 32'h0);
          chk({p, " busy"}, busy[g], {31'h0, pend});
          if (rv) pend = 1'b0;
          if (dw) wc = 0;
          else if (d_req[g]) wc = (wc < 15) ? wc + 1 : 15;
          if ((cw || dw) && e_we) rmem[e_addr[9:2]] = e_wdata;
          if ((cw || dw) && !e_we) begin
            pend = 1'b1; due = cyc + L; own = dw; rdat = rmem[e_addr[9:2]]; nxt = cyc + L;
          end
        end
        cyc++;
      end
    end
  end

  typedef struct {
    logic       c;
    logic       d;
    logic       eg_c;
    logic       eg_d;
    logic [3:0] wc;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       tbl [10];
    logic [6:0] rq, eg, ev;
    tbl = '{'{1'b1, 1'b1, 1'b1, 1'b0, 4'd0}, '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2}, '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3},
            '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4}, '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1}, '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2},
            '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3}, '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4}};
    for (int k = 0; k < N; k++) begin
      c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = 32'h0; c_wdata[k] = 32'h0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Plain C read, RD_LAT=2
    step(); c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h100; #2;
    chk("t1 c_gnt", c_gnt[1], 32'h1);
    chk("t1 mem_en", mem_en[1], 32'h1);
    chk("t1 mem_addr", mem_addr[1], 32'h100);
    step(); c_req[1] = 1'b0; #2;
    chk("t1 busy t+1", busy[1], 32'h1);
    chk("t1 c_rvalid t+1", c_rvalid[1], 32'h0);
    step(); #2;
    chk("t1 c_rvalid t+2", c_rvalid[1], 32'h1);
    chk("t1 c_rdata", c_rdata[1], 32'hDEADBEEF);
    chk("t1 busy t+2", busy[1], 32'h1);
    chk("t1 d_rvalid", d_rvalid[1], 32'h0);
    step(); #2;
    chk("t1 busy t+3", busy[1], 32'h0);

    // D write then D read-back
    step(); d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h40; d_wdata[1] = 32'h12345678; #2;
    chk("t2 d_gnt wr", d_gnt[1], 32'h1);
    chk("t2 mem_we", mem_we[1], 32'h1);
    chk("t2 mem_wdata", mem_wdata[1], 32'h12345678);
    chk("t2 busy wr", busy[1], 32'h0);
    step(); d_we[1] = 1'b0; #2;
    chk("t2 d_gnt rd", d_gnt[1], 32'h1);
    step(); d_req[1] = 1'b0; #2;
    step(); #2;
    chk("t2 d_rvalid", d_rvalid[1], 32'h1);
    chk("t2 d_rdata", d_rdata[1], 32'h12345678);
    step();

    // Contention with forced D grant, RD_LAT=1
    c_addr[0] = 32'h10; d_addr[0] = 32'h20; c_we[0] = 1'b0; d_we[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); c_req[0] = tbl[i].c; d_req[0] = tbl[i].d; #2;
      chk($sformatf("t3 c_gnt[%0d]", i), c_gnt[0], {31'h0, tbl[i].eg_c});
      chk($sformatf("t3 d_gnt[%0d]", i), d_gnt[0], {31'h0, tbl[i].eg_d});
      chk($sformatf("t3 wait_cnt[%0d]", i), {28'h0, gen_inst[0].u_dut.wait_cnt_r}, {28'h0, tbl[i].wc});
    end
    step(); c_req[0] = 1'b0; d_req[0] = 1'b0; #2;
    chk("t3 wait_cnt after", {28'h0, gen_inst[0].u_dut.wait_cnt_r}, 32'h0);

    // D blocked behind a C read, RD_LAT=3
    step(); c_req[2] = 1'b1; c_we[2] = 1'b0; c_addr[2] = 32'h80; #2;
    chk("t4 c_gnt", c_gnt[2], 32'h1);
    step(); c_req[2] = 1'b0; d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h44; #2;
    chk("t4 d_gnt t+1", d_gnt[2], 32'h0);
    step(); #2;
    chk("t4 d_gnt t+2", d_gnt[2], 32'h0);
    step(); #2;
    chk("t4 d_gnt t+3", d_gnt[2], 32'h1);
    chk("t4 c_rvalid t+3", c_rvalid[2], 32'h1);
    step(); d_req[2] = 1'b0;
    step(); step(); #2;
    chk("t4 d_rvalid t+6", d_rvalid[2], 32'h1);
    chk("t4 d_rdata", d_rdata[2], init_word(17));
    step();

    // Reset mid-read, RD_LAT=3
    step(); c_req[2] = 1'b1; c_addr[2] = 32'h100; #2;
    chk("t5 c_gnt", c_gnt[2], 32'h1);
    step(); rst = 1'b1; #2;
    chk("t5 rst c_gnt", c_gnt[2], 32'h0);
    chk("t5 rst mem_en", mem_en[2], 32'h0);
    chk("t5 rst busy", busy[2], 32'h0);
    step(); rst = 1'b0; #2;
    chk("t5 post c_gnt", c_gnt[2], 32'h1);
    step(); c_req[2] = 1'b0; #2;
    chk("t5 c_rvalid t+3", c_rvalid[2], 32'h0);
    step(); #2;
    chk("t5 c_rvalid t+4", c_rvalid[2], 32'h0);
    step(); #2;
    chk("t5 c_rvalid t+5", c_rvalid[2], 32'h1);
    chk("t5 c_rdata", c_rdata[2], 32'hDEADBEEF);
    step();

    // C re-requests in its own rvalid cycle, RD_LAT=2
    c_addr[1] = 32'h100; c_we[1] = 1'b0;
    rq = 7'b0011111; eg = 7'b0010101; ev = 7'b1010100;
    for (int i = 0; i < 7; i++) begin
      step(); c_req[1] = rq[i]; #2;
      chk($sformatf("t6 c_gnt[%0d]", i), c_gnt[1], {31'h0, eg[i]});
      chk($sformatf("t6 mem_en[%0d]", i), mem_en[1], {31'h0, eg[i]});
      chk($sformatf("t6 c_rvalid[%0d]", i), c_rvalid[1], {31'h0, ev[i]});
    end
    step();

    // Random traffic on all instances against the reference model
    for (int n = 0; n < 800; n++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < N; k++) begin
        c_req[k]   = ($urandom_range(0, 9) < 6);
        c_we[k]    = ($urandom_range(0, 3) == 0);
        c_addr[k]  = 32'($urandom_range(0, 63)) << 2;
        c_wdata[k] = $urandom;
        d_req[k]   = ($urandom_range(0, 9) < 5);
        d_we[k]    = ($urandom_range(0, 2) == 0);
        d_addr[k]  = 32'($urandom_range(0, 63)) << 2;
        d_wdata[k] = $urandom;
      end
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      c_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
    repeat (6) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
